upload_arbiter: RTL and testbench

//   Merges N data-upload streams (UART, I2C, future handlers) onto the single upload port
//   of the command processor, which frames the bytes for USB.

---
 rtl/upload_arbiter_if.sv | 47 ++++
 rtl/upload_arbiter.sv | 175 +++++++++++++++++
 tb/tb_upload_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/upload_arbiter_if.sv
// rtl/upload_arbiter_if.sv - source-side and port-side signal bundle for upload_arbiter
//
// Purpose: groups the N upload source streams and the single merged upload port
// into one bundle. The master modport is the arbiter's view; slave is the
// environment's view (sources plus command processor).
//
// Signals:
//   src_req       per-source packet request, high for the whole packet
//   src_data      per-source byte, source i on [8*i+7:8*i]
//   src_source    per-source source-ID byte, same packing
//   src_valid     per-source byte valid
//   src_ready     per-source byte accept (driven by the arbiter)
//   upload_req    merged packet request to the command processor
//   upload_data   merged byte
//   upload_source source-ID byte of the granted source
//   upload_valid  merged byte valid
//   upload_ready  command processor accept
//   grant_id      index of the granted source
//   timeout_pulse one-cycle pulse on a forced release
interface upload_arbiter_if #(
  parameter int NUM_SRC = 2
) ();
  logic [NUM_SRC-1:0]   src_req;
  logic [8*NUM_SRC-1:0] src_data;
  logic [8*NUM_SRC-1:0] src_source;
  logic [NUM_SRC-1:0]   src_valid;
  logic [NUM_SRC-1:0]   src_ready;
  logic                 upload_req;
  logic [7:0]           upload_data;
  logic [7:0]           upload_source;
  logic                 upload_valid;
  logic                 upload_ready;
  logic [7:0]           grant_id;
  logic                 timeout_pulse;

  modport master (
    input  src_req, src_data, src_source, src_valid, upload_ready,
    output src_ready, upload_req, upload_data, upload_source, upload_valid,
           grant_id, timeout_pulse
  );

  modport slave (
    output src_req, src_data, src_source, src_valid, upload_ready,
    input  src_ready, upload_req, upload_data, upload_source, upload_valid,
           grant_id, timeout_pulse
  );
endinterface

// File: rtl/upload_arbiter.sv
// rtl/upload_arbiter.sv - packet-granular round-robin merge of N upload sources
//
// Purpose: merges NUM_SRC upload streams onto the single upload port of the
// command processor. A source owns the port from its grant until it drops
// src_req; a stall timeout forcibly releases a hung owner and locks it out
// until it drops its request. Data path is a combinational mux (zero latency);
// only state, grant, round-robin pointer, lockout and stall counter are stored.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    upload_arbiter_if.master (sources in, merged port out, grant_id,
//          timeout_pulse)
module upload_arbiter #(
  parameter int NUM_SRC        = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  upload_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  // With TIMEOUT_CYCLES = 0 this wraps to all ones, but the compare is gated off.
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0]       LAST_IDX   = 8'(NUM_SRC - 1);

  state_t             state_q, state_d;
  logic [7:0]         grant_q, grant_d;
  logic [7:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0] lockout_q, lockout_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic [NUM_SRC-1:0] elig;
  logic               found;
  logic [7:0]         pick;

  logic               g_req;
  logic               g_valid;
  logic [7:0]         g_data;
  logic [7:0]         g_source;
  logic               xfer;

  logic               upload_req_c;
  logic               upload_valid_c;
  logic [7:0]         upload_data_c;
  logic [7:0]         upload_source_c;
  logic [NUM_SRC-1:0] src_ready_c;
  logic               timeout_c;

  // Select the granted source's signals.
  always_comb begin
    g_req    = 1'b0;
    g_valid  = 1'b0;
    g_data   = 8'd0;
    g_source = 8'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == 8'(i)) begin
        g_req    = bus.src_req[i];
        g_valid  = bus.src_valid[i];
        g_data   = bus.src_data[8*i +: 8];
        g_source = bus.src_source[8*i +: 8];
      end
    end
  end

  // Round-robin scan: first eligible index at or above rr_ptr, then wrap to
  // the indices below it.
  always_comb begin
    elig  = bus.src_req & ~lockout_q;
    found = 1'b0;
    pick  = 8'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && elig[i] && (i >= int'(rr_ptr_q))) begin
        found = 1'b1;
        pick  = 8'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && elig[i] && (i < int'(rr_ptr_q))) begin
        found = 1'b1;
        pick  = 8'(i);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_ptr_d        = rr_ptr_q;
    stall_d         = stall_q;
    // A source that drops its request is released from lockout.
    lockout_d       = lockout_q & bus.src_req;
    upload_req_c    = 1'b0;
    upload_valid_c  = 1'b0;
    upload_data_c   = 8'd0;
    upload_source_c = 8'd0;
    src_ready_c     = '0;
    timeout_c       = 1'b0;
    xfer            = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = ACTIVE;
          grant_d  = pick;
          rr_ptr_d = (pick == LAST_IDX) ? 8'd0 : pick + 8'd1;
          stall_d  = '0;
        end
      end

      ACTIVE: begin
        upload_req_c    = 1'b1;
        upload_data_c   = g_data;
        upload_source_c = g_source;
        upload_valid_c  = g_valid & g_req;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant_q == 8'(i)) src_ready_c[i] = bus.upload_ready & g_req;
        end
        xfer = g_valid & g_req & bus.upload_ready;

        if (!g_req) begin
          state_d = GAP;
        end else if (xfer) begin
          stall_d = '0;
        end else if (TIMEOUT_EN && (stall_q == STALL_LAST)) begin
          timeout_c = 1'b1;
          state_d   = GAP;
          for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 8'(i)) lockout_d[i] = 1'b1;
          end
        end else if (stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
      end

      // One dead cycle so the processor sees the packet boundary.
      GAP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 8'd0;
      rr_ptr_q  <= 8'd0;
      lockout_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      lockout_q <= lockout_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.upload_req    = upload_req_c;
  assign bus.upload_valid  = upload_valid_c;
  assign bus.upload_data   = upload_data_c;
  assign bus.upload_source = upload_source_c;
  assign bus.src_ready     = src_ready_c;
  assign bus.grant_id      = grant_q;
  assign bus.timeout_pulse = timeout_c;

endmodule

// File: tb/tb_upload_arbiter.sv
// tb/tb_upload_arbiter.sv - directed self-checking bench for upload_arbiter
module tb_upload_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  src_req;
  logic [1:0]  src_valid;
  logic [15:0] src_data;
  logic [15:0] src_source;
  logic        upload_ready;

  int n_vec  = 0;
  int n_err  = 0;
  int xfer_a = 0;

  always #5 clk = ~clk;

  upload_arbiter_if #(.NUM_SRC(2)) bus_a ();
  upload_arbiter_if #(.NUM_SRC(2)) bus_b ();

  assign bus_a.src_req      = src_req;
  assign bus_a.src_valid    = src_valid;
  assign bus_a.src_data     = src_data;
  assign bus_a.src_source   = src_source;
  assign bus_a.upload_ready = upload_ready;
  assign bus_b.src_req      = src_req;
  assign bus_b.src_valid    = src_valid;
  assign bus_b.src_data     = src_data;
  assign bus_b.src_source   = src_source;
  assign bus_b.upload_ready = upload_ready;

  upload_arbiter #(.NUM_SRC(2), .TIMEOUT_CYCLES(65535), .CNT_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.master)
  );

  upload_arbiter #(.NUM_SRC(2), .TIMEOUT_CYCLES(8), .CNT_W(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
  );

  // Source-0 byte transfers accepted by dut_a.
  always @(negedge clk) begin
    if (rst_n && src_valid[0] && bus_a.src_ready[0]) xfer_a <= xfer_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] valid,
                       input logic [7:0] d0, input logic [7:0] d1, input logic rdy);
    src_req      = req;
    src_valid    = valid;
    src_data     = {d1, d0};
    upload_ready = rdy;
    #1;
  endtask

  // grant_id is only meaningful while upload_req is expected high.
  task automatic expect_out(input bit use_b, input string tag, input logic req,
                            input logic valid, input logic [7:0] data,
                            input logic [7:0] source, input logic [1:0] rdy,
                            input logic [7:0] gid, input logic tp);
    logic       o_req, o_valid, o_tp;
    logic [7:0] o_data, o_src, o_gid;
    logic [1:0] o_rdy;
    if (use_b) begin
      o_req = bus_b.upload_req;   o_valid = bus_b.upload_valid; o_tp  = bus_b.timeout_pulse;
      o_data = bus_b.upload_data; o_src = bus_b.upload_source;  o_gid = bus_b.grant_id;
      o_rdy = bus_b.src_ready;
    end else begin
      o_req = bus_a.upload_req;   o_valid = bus_a.upload_valid; o_tp  = bus_a.timeout_pulse;
      o_data = bus_a.upload_data; o_src = bus_a.upload_source;  o_gid = bus_a.grant_id;
      o_rdy = bus_a.src_ready;
    end
    chk({tag, ".upload_req"},    32'(o_req),   32'(req));
    chk({tag, ".upload_valid"},  32'(o_valid), 32'(valid));
    chk({tag, ".upload_data"},   32'(o_data),  32'(data));
    chk({tag, ".upload_source"}, 32'(o_src),   32'(source));
    chk({tag, ".src_ready"},     32'(o_rdy),   32'(rdy));
    chk({tag, ".timeout_pulse"}, 32'(o_tp),    32'(tp));
    if (req) chk({tag, ".grant_id"}, 32'(o_gid), 32'(gid));
  endtask

  // Inputs are busy during reset so the zero outputs actually show gating.
  task automatic reset_both();
    rst_n      = 1'b0;
    src_source = {8'hB1, 8'hA0};
    drive(2'b11, 2'b11, 8'h5A, 8'hC3, 1'b1);
    step();
    step();
    expect_out(0, "rst_a", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    expect_out(1, "rst_b", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    chk("rst_a.grant_id", 32'(bus_a.grant_id), 32'h0);
    chk("rst_b.grant_id", 32'(bus_b.grant_id), 32'h0);
    drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int x0;

    // 1: single source, three bytes, then the packet boundary.
    reset_both();
    drive(2'b01, 2'b01, 8'h11, 8'h55, 1'b1);
    expect_out(0, "t1.idle", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    expect_out(0, "t1.byte0", 1, 1, 8'h11, 8'hA0, 2'b01, 8'h00, 0);
    expect_out(1, "t1.byte0_b", 1, 1, 8'h11, 8'hA0, 2'b01, 8'h00, 0);
    step();
    drive(2'b01, 2'b01, 8'h22, 8'h55, 1'b1);
    expect_out(0, "t1.byte1", 1, 1, 8'h22, 8'hA0, 2'b01, 8'h00, 0);
    step();
    drive(2'b01, 2'b01, 8'h33, 8'h55, 1'b1);
    expect_out(0, "t1.byte2", 1, 1, 8'h33, 8'hA0, 2'b01, 8'h00, 0);
    step();
    drive(2'b00, 2'b01, 8'h44, 8'h55, 1'b1);
    expect_out(0, "t1.drop", 1, 0, 8'h44, 8'hA0, 2'b00, 8'h00, 0);
    step();
    expect_out(0, "t1.gap", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    expect_out(0, "t1.idle2", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);

    // 2: simultaneous requests and round-robin hand-over.
    reset_both();
    drive(2'b11, 2'b11, 8'h01, 8'h02, 1'b1);
    expect_out(0, "t2.idle", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    expect_out(0, "t2.own0", 1, 1, 8'h01, 8'hA0, 2'b01, 8'h00, 0);
    step();
    drive(2'b10, 2'b11, 8'h01, 8'h02, 1'b1);
    expect_out(0, "t2.drop0", 1, 0, 8'h01, 8'hA0, 2'b00, 8'h00, 0);
    step();
    expect_out(0, "t2.gap0", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    expect_out(0, "t2.idle0", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    expect_out(0, "t2.own1", 1, 1, 8'h02, 8'hB1, 2'b10, 8'h01, 0);
    drive(2'b00, 2'b00, 8'h01, 8'h02, 1'b1);
    expect_out(0, "t2.drop1", 1, 0, 8'h02, 8'hB1, 2'b00, 8'h01, 0);
    step();
    expect_out(0, "t2.gap1", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    drive(2'b11, 2'b11, 8'h01, 8'h02, 1'b1);
    expect_out(0, "t2.idle1", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    expect_out(0, "t2.regrant0", 1, 1, 8'h01, 8'hA0, 2'b01, 8'h00, 0);

    // 3: backpressure mid-packet on the untimed instance.
    reset_both();
    x0 = xfer_a;
    drive(2'b01, 2'b01, 8'h11, 8'h55, 1'b1);
    step();
    expect_out(0, "t3.byte0", 1, 1, 8'h11, 8'hA0, 2'b01, 8'h00, 0);
    step();
    drive(2'b01, 2'b01, 8'h22, 8'h55, 1'b0);
    for (int k = 0; k < 10; k++) begin
      expect_out(0, $sformatf("t3.stall%0d", k), 1, 1, 8'h22, 8'hA0, 2'b00, 8'h00, 0);
      step();
    end
    drive(2'b01, 2'b01, 8'h22, 8'h55, 1'b1);
    expect_out(0, "t3.resume", 1, 1, 8'h22, 8'hA0, 2'b01, 8'h00, 0);
    step();
    drive(2'b01, 2'b01, 8'h33, 8'h55, 1'b1);
    expect_out(0, "t3.byte2", 1, 1, 8'h33, 8'hA0, 2'b01, 8'h00, 0);
    step();
    drive(2'b00, 2'b00, 8'h00, 8'h55, 1'b1);
    chk("t3.xfer_count", 32'(xfer_a - x0), 32'd3);

    // 4: stall timeout, lockout, and regrant only after req is dropped.
    reset_both();
    drive(2'b11, 2'b00, 8'h77, 8'h88, 1'b1);
    expect_out(1, "t4.idle", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    for (int k = 1; k <= 8; k++) begin
      expect_out(1, $sformatf("t4.stall%0d", k), 1, 0, 8'h77, 8'hA0, 2'b01, 8'h00,
                 (k == 8) ? 1'b1 : 1'b0);
      step();
    end
    expect_out(1, "t4.gap", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    expect_out(1, "t4.idle2", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    expect_out(1, "t4.own1", 1, 0, 8'h88, 8'hB1, 2'b10, 8'h01, 0);
    drive(2'b01, 2'b00, 8'h77, 8'h88, 1'b1);
    expect_out(1, "t4.drop1", 1, 0, 8'h88, 8'hB1, 2'b00, 8'h01, 0);
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      expect_out(1, $sformatf("t4.locked%0d", k), 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
      step();
    end
    drive(2'b00, 2'b00, 8'h77, 8'h88, 1'b1);
    step();
    drive(2'b01, 2'b00, 8'h77, 8'h88, 1'b1);
    expect_out(1, "t4.rereq", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    expect_out(1, "t4.regrant0", 1, 0, 8'h77, 8'hA0, 2'b01, 8'h00, 0);

    // 5: asynchronous reset mid-packet, then a lone source 1 request.
    reset_both();
    drive(2'b01, 2'b01, 8'h11, 8'h66, 1'b1);
    step();
    expect_out(0, "t5.own0", 1, 1, 8'h11, 8'hA0, 2'b01, 8'h00, 0);
    step();
    #1;
    rst_n = 1'b0;
    #1;
    expect_out(0, "t5.rst_a", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    expect_out(1, "t5.rst_b", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    chk("t5.rst_a.grant_id", 32'(bus_a.grant_id), 32'h0);
    step();
    rst_n = 1'b1;
    drive(2'b10, 2'b10, 8'h11, 8'h66, 1'b1);
    expect_out(0, "t5.idle", 0, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0);
    step();
    expect_out(0, "t5.own1", 1, 1, 8'h66, 8'hB1, 2'b10, 8'h01, 0);
    expect_out(1, "t5.own1_b", 1, 1, 8'h66, 8'hB1, 2'b10, 8'h01, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
